// File: rtl/five_state_pkg.sv
// five_state_pkg: definitions shared by the 2-bit-symbol five-state receiver
// and its transmitter.
//   rx_state_e   - receiver state encodings S0..S4 (3-bit)
//   ctrl_state_e - transmitter control states IDLE/SEND/GAP
//   IDLE_SYM_DEFAULT - symbol driven on the line when no word is being sent
//   rx_next/rx_out   - receiver next-state and Mealy-output tables
package five_state_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] IDLE_SYM_DEFAULT = 2'b00;

  // Takes a raw 3-bit state so the unused encodings 5..7 can be handled.
  function automatic logic [2:0] rx_next(input logic [2:0] st, input logic [1:0] sym);
    logic [2:0] nxt;
    nxt = S0;
    case (st)
      S0: begin
        case (sym)
          2'b00:   nxt = S0;
          2'b01:   nxt = S4;
          2'b10:   nxt = S1;
          default: nxt = S2;
        endcase
      end
      S1: begin
        if (sym == 2'b00)      nxt = S0;
        else if (sym == 2'b10) nxt = S2;
        else                   nxt = S1;
      end
      S2:      nxt = sym[1] ? S3 : S1;
      S3:      nxt = sym[0] ? S4 : S3;
      S4:      nxt = (sym == 2'b11) ? S4 : S0;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

  function automatic logic rx_out(input logic [2:0] st, input logic [1:0] sym);
    logic o;
    o = 1'b0;
    case (st)
      S0:      o = (sym != 2'b00);
      S1:      o = 1'b0;
      S2:      o = sym[1];
      S3:      o = 1'b1;
      S4:      o = sym[1];
      default: o = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/five_state_sym_tx_if.sv
// five_state_sym_tx_if: word-in handshake plus serial symbol and shadow
// receiver outputs of five_state_sym_tx.
//   master - word source / observer (drives word_in, word_valid)
//   slave  - the transmitter (drives everything else)
interface five_state_sym_tx_if #(
  parameter int unsigned NSYM = 4
);
  logic [2*NSYM-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [1:0]        sym_out;
  logic              sym_valid;
  logic              busy;
  logic              done;
  logic [2:0]        exp_state;
  logic              exp_out;

  modport master (
    output word_in, word_valid,
    input  word_ready, sym_out, sym_valid, busy, done, exp_state, exp_out
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, sym_out, sym_valid, busy, done, exp_state, exp_out
  );
endinterface

// File: rtl/five_state_shadow.sv
// five_state_shadow: copy of the five-state receiver FSM.
//   clk, rst - clock, asynchronous active-high reset
//   sym      - symbol on the line this cycle
//   state    - receiver state (S0..S4)
//   out      - receiver Mealy output for (state, sym)
module five_state_shadow
  import five_state_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym,
  output logic [2:0] state,
  output logic       out
);

  logic [2:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S0;
    else     state_q <= rx_next(state_q, sym);
  end

  assign state = state_q;
  assign out   = rx_out(state_q, sym);

endmodule

// File: rtl/five_state_sym_tx.sv
// five_state_sym_tx: accepts an NSYM-symbol word over a valid/ready handshake
// and serializes it LSB symbol first, one 2-bit symbol per clock, followed by
// GAP idle symbols. A shadow receiver predicts the far end's state/output.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - five_state_sym_tx_if.slave (word_in/word_valid/word_ready,
//              sym_out/sym_valid, busy, done, exp_state/exp_out)
module five_state_sym_tx
  import five_state_pkg::*;
#(
  parameter int unsigned NSYM     = 4,
  parameter int unsigned GAP      = 1,
  parameter logic [1:0]  IDLE_SYM = IDLE_SYM_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  five_state_sym_tx_if.slave    bus
);

  localparam int unsigned CW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] LAST   = CW'(NSYM - 1);
  localparam logic [CW-1:0] PENULT = CW'(NSYM - 2);
  localparam logic [GW-1:0] GLAST  = GW'(GAP - 1);

  ctrl_state_e        state_q;
  logic [2*NSYM-1:0]  sh_q;
  logic [1:0]         sym_q;
  logic               valid_q;
  logic               done_q;
  logic [CW-1:0]      cnt_q;
  logic [GW-1:0]      gcnt_q;
  logic [2:0]         exp_state_w;
  logic               exp_out_w;

  // The handshake cycle already loads symbol 0 onto the output register, so
  // cnt_q tracks the index of the symbol currently on sym_out; done is set
  // while loading the last one so it lines up with that symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      sym_q   <= IDLE_SYM;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.word_valid) begin
            sym_q   <= bus.word_in[1:0];
            sh_q    <= bus.word_in >> 2;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (cnt_q == LAST) begin
            sym_q   <= IDLE_SYM;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            state_q <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            sym_q  <= sh_q[1:0];
            sh_q   <= sh_q >> 2;
            cnt_q  <= cnt_q + 1'b1;
            done_q <= (cnt_q == PENULT);
          end
        end
        ST_GAP: begin
          if (gcnt_q == GLAST) begin
            gcnt_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: begin
          sym_q   <= IDLE_SYM;
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  five_state_shadow u_shadow (
    .clk   (clk),
    .rst   (rst),
    .sym   (sym_q),
    .state (exp_state_w),
    .out   (exp_out_w)
  );

  assign bus.word_ready = (state_q == ST_IDLE) && !rst;
  assign bus.sym_out    = sym_q;
  assign bus.sym_valid  = valid_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.exp_state  = exp_state_w;
  assign bus.exp_out    = exp_out_w;

endmodule

// File: tb/tb_five_state_sym_tx.sv
module tb_five_state_sym_tx;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  five_state_sym_tx_if #(.NSYM(4)) b1 ();
  five_state_sym_tx_if #(.NSYM(2)) b2 ();

  five_state_sym_tx #(.NSYM(4), .GAP(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  five_state_sym_tx #(.NSYM(2), .GAP(0)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // back-to-back stream: words E4, 1B, 9C
  int b2b_syms [12] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 3, 1, 2};
  // NSYM=2/GAP=0 per-cycle expectations, cycles 0..9
  int sw_rdy  [10] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  int sw_sym  [10] = '{0, 2, 3, 0, 3, 2, 0, 1, 0, 0};
  int sw_val  [10] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
  int sw_done [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
  int sw_out  [10] = '{0, 1, 0, 0, 1, 1, 1, 1, 0, 0};
  int sw_st   [10] = '{0, 0, 1, 1, 0, 2, 3, 3, 4, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.word_in = '0; b1.word_valid = 1'b0;
    b2.word_in = '0; b2.word_valid = 1'b0;
    tick(); tick();
    checks++; if (b1.sym_out !== 2'b00) $display("FAIL reset sym_out: got %0d expected 0", b1.sym_out); else passes++;
    checks++; if (b1.sym_valid !== 1'b0) $display("FAIL reset sym_valid: got %0b expected 0", b1.sym_valid); else passes++;
    checks++; if (b1.done !== 1'b0) $display("FAIL reset done: got %0b expected 0", b1.done); else passes++;
    checks++; if (b1.busy !== 1'b0) $display("FAIL reset busy: got %0b expected 0", b1.busy); else passes++;
    checks++; if (b1.exp_state !== 3'd0) $display("FAIL reset exp_state: got %0d expected 0", b1.exp_state); else passes++;
    checks++; if (b1.exp_out !== 1'b0) $display("FAIL reset exp_out: got %0b expected 0", b1.exp_out); else passes++;
    checks++; if (b1.word_ready !== 1'b0) $display("FAIL reset word_ready in rst: got %0b expected 0", b1.word_ready); else passes++;
    checks++; if (b2.word_ready !== 1'b0) $display("FAIL reset word_ready2 in rst: got %0b expected 0", b2.word_ready); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (b1.word_ready !== 1'b1) $display("FAIL reset word_ready after release: got %0b expected 1", b1.word_ready); else passes++;
    tick();
  endtask

  // syms: expected symbol k at [2k+1:2k]; outs: exp_out per symbol;
  // sts: exp_state after symbol k at [3k+2:3k]; gout/gst: gap-cycle output
  // and state after the gap symbol.
  task automatic test_word(input string name, input logic [7:0] word,
                           input logic [7:0] syms, input logic [3:0] outs,
                           input logic [11:0] sts, input logic gout,
                           input logic [2:0] gst);
    checks++; if (b1.word_ready !== 1'b1) $display("FAIL %s ready before: got %0b expected 1", name, b1.word_ready); else passes++;
    b1.word_in = word;
    b1.word_valid = 1'b1;
    tick();
    b1.word_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (b1.sym_out !== syms[2*k +: 2]) $display("FAIL %s sym[%0d]: got %0d expected %0d", name, k, b1.sym_out, syms[2*k +: 2]); else passes++;
      checks++; if (b1.sym_valid !== 1'b1) $display("FAIL %s sym_valid[%0d]: got %0b expected 1", name, k, b1.sym_valid); else passes++;
      checks++; if (b1.done !== (k == 3)) $display("FAIL %s done[%0d]: got %0b expected %0b", name, k, b1.done, (k == 3)); else passes++;
      checks++; if (b1.exp_out !== outs[k]) $display("FAIL %s exp_out[%0d]: got %0b expected %0b", name, k, b1.exp_out, outs[k]); else passes++;
      checks++; if (b1.word_ready !== 1'b0) $display("FAIL %s ready while sending[%0d]: got %0b expected 0", name, k, b1.word_ready); else passes++;
      if (k > 0) begin
        checks++; if (b1.exp_state !== sts[3*(k-1) +: 3]) $display("FAIL %s exp_state[%0d]: got %0d expected %0d", name, k-1, b1.exp_state, sts[3*(k-1) +: 3]); else passes++;
      end
      tick();
    end
    checks++; if (b1.exp_state !== sts[9 +: 3]) $display("FAIL %s exp_state[3]: got %0d expected %0d", name, b1.exp_state, sts[9 +: 3]); else passes++;
    checks++; if (b1.sym_valid !== 1'b0) $display("FAIL %s gap sym_valid: got %0b expected 0", name, b1.sym_valid); else passes++;
    checks++; if (b1.sym_out !== 2'b00) $display("FAIL %s gap sym_out: got %0d expected 0", name, b1.sym_out); else passes++;
    checks++; if (b1.done !== 1'b0) $display("FAIL %s gap done: got %0b expected 0", name, b1.done); else passes++;
    checks++; if (b1.busy !== 1'b1) $display("FAIL %s gap busy: got %0b expected 1", name, b1.busy); else passes++;
    checks++; if (b1.exp_out !== gout) $display("FAIL %s gap exp_out: got %0b expected %0b", name, b1.exp_out, gout); else passes++;
    tick();
    checks++; if (b1.exp_state !== gst) $display("FAIL %s gap exp_state: got %0d expected %0d", name, b1.exp_state, gst); else passes++;
    checks++; if (b1.word_ready !== 1'b1) $display("FAIL %s idle ready: got %0b expected 1", name, b1.word_ready); else passes++;
    checks++; if (b1.busy !== 1'b0) $display("FAIL %s idle busy: got %0b expected 0", name, b1.busy); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    int         hs_cyc [$];
    logic [1:0] got [$];
    int         nw;
    logic       hs;
    w[0] = 8'hE4; w[1] = 8'h1B; w[2] = 8'h9C;
    nw = 0;
    b1.word_in = w[0];
    b1.word_valid = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (b1.sym_valid) got.push_back(b1.sym_out);
      hs = b1.word_ready && b1.word_valid;
      if (hs) hs_cyc.push_back(c);
      tick();
      if (hs) begin
        nw++;
        if (nw < 3) b1.word_in = w[nw];
        else        b1.word_valid = 1'b0;
      end
    end
    checks++; if (hs_cyc.size() !== 3) $display("FAIL b2b handshake count: got %0d expected 3", hs_cyc.size()); else passes++;
    for (int i = 0; i < 3; i++) begin
      if (i < hs_cyc.size()) begin
        checks++; if (hs_cyc[i] !== 6 * i) $display("FAIL b2b handshake cycle[%0d]: got %0d expected %0d", i, hs_cyc[i], 6 * i); else passes++;
      end
    end
    checks++; if (got.size() !== 12) $display("FAIL b2b symbol count: got %0d expected 12", got.size()); else passes++;
    for (int i = 0; i < 12; i++) begin
      if (i < got.size()) begin
        checks++; if (int'(got[i]) !== b2b_syms[i]) $display("FAIL b2b sym[%0d]: got %0d expected %0d", i, got[i], b2b_syms[i]); else passes++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] esym;
    logic [3:0] eout;
    b1.word_in = 8'hE4;
    b1.word_valid = 1'b1;
    tick();
    b1.word_valid = 1'b0;
    tick();
    checks++; if (b1.sym_out !== 2'b01) $display("FAIL rstmid 2nd sym: got %0d expected 1", b1.sym_out); else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (b1.sym_valid !== 1'b0) $display("FAIL rstmid sym_valid: got %0b expected 0", b1.sym_valid); else passes++;
    checks++; if (b1.sym_out !== 2'b00) $display("FAIL rstmid sym_out: got %0d expected 0", b1.sym_out); else passes++;
    checks++; if (b1.exp_state !== 3'd0) $display("FAIL rstmid exp_state: got %0d expected 0", b1.exp_state); else passes++;
    checks++; if (b1.done !== 1'b0) $display("FAIL rstmid done: got %0b expected 0", b1.done); else passes++;
    checks++; if (b1.busy !== 1'b0) $display("FAIL rstmid busy: got %0b expected 0", b1.busy); else passes++;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (b1.done !== 1'b0) $display("FAIL rstmid done held[%0d]: got %0b expected 0", c, b1.done); else passes++;
    end
    rst = 1'b0;
    #1;
    checks++; if (b1.word_ready !== 1'b1) $display("FAIL rstmid ready after release: got %0b expected 1", b1.word_ready); else passes++;
    // 8'h1B from S0: symbols 11,10,01,00 -> outputs 1,1,1,0, ending in S0
    esym = 8'b00_01_10_11;
    eout = 4'b0111;
    b1.word_in = 8'h1B;
    b1.word_valid = 1'b1;
    tick();
    b1.word_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (b1.sym_out !== esym[2*k +: 2]) $display("FAIL rstmid resend sym[%0d]: got %0d expected %0d", k, b1.sym_out, esym[2*k +: 2]); else passes++;
      checks++; if (b1.exp_out !== eout[k]) $display("FAIL rstmid resend exp_out[%0d]: got %0b expected %0b", k, b1.exp_out, eout[k]); else passes++;
      checks++; if (b1.done !== (k == 3)) $display("FAIL rstmid resend done[%0d]: got %0b expected %0b", k, b1.done, (k == 3)); else passes++;
      tick();
    end
    checks++; if (b1.exp_state !== 3'd0) $display("FAIL rstmid resend final state: got %0d expected 0", b1.exp_state); else passes++;
    tick();
  endtask

  task automatic test_sweep();
    logic [3:0] w [3];
    int         nw;
    logic       hs;
    w[0] = 4'b1110; w[1] = 4'b1011; w[2] = 4'b0001;
    nw = 0;
    b2.word_in = w[0];
    b2.word_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++; if (int'(b2.word_ready) !== sw_rdy[c]) $display("FAIL sweep ready[%0d]: got %0b expected %0d", c, b2.word_ready, sw_rdy[c]); else passes++;
      checks++; if (int'(b2.sym_out) !== sw_sym[c]) $display("FAIL sweep sym[%0d]: got %0d expected %0d", c, b2.sym_out, sw_sym[c]); else passes++;
      checks++; if (int'(b2.sym_valid) !== sw_val[c]) $display("FAIL sweep sym_valid[%0d]: got %0b expected %0d", c, b2.sym_valid, sw_val[c]); else passes++;
      checks++; if (int'(b2.done) !== sw_done[c]) $display("FAIL sweep done[%0d]: got %0b expected %0d", c, b2.done, sw_done[c]); else passes++;
      checks++; if (int'(b2.exp_out) !== sw_out[c]) $display("FAIL sweep exp_out[%0d]: got %0b expected %0d", c, b2.exp_out, sw_out[c]); else passes++;
      checks++; if (int'(b2.exp_state) !== sw_st[c]) $display("FAIL sweep exp_state[%0d]: got %0d expected %0d", c, b2.exp_state, sw_st[c]); else passes++;
      hs = b2.word_ready && b2.word_valid;
      tick();
      if (hs) begin
        nw++;
        if (nw < 3) b2.word_in = w[nw];
        else        b2.word_valid = 1'b0;
      end
    end
    checks++; if (b2.exp_state !== 3'd0) $display("FAIL sweep final state: got %0d expected 0", b2.exp_state); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_word("word1", 8'b11_10_01_00, 8'b11_10_01_00, 4'b1110,
              {3'd2, 3'd0, 3'd4, 3'd0}, 1'b0, 3'd1);
    test_word("word2", 8'b00_11_11_10, 8'b00_11_11_10, 4'b0001,
              {3'd0, 3'd1, 3'd1, 3'd1}, 1'b0, 3'd0);
    test_word("word3", 8'b01_00_10_11, 8'b01_00_10_11, 4'b1111,
              {3'd4, 3'd3, 3'd3, 3'd2}, 1'b0, 3'd0);
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
